sd_result_writer: RTL and testbench
===================================

# sd_result_writer

Avalon-MM write master that drains filtered samples from the notch-filter datapath into SDRAM. It accepts 32-bit results over a valid/ready stream and buffers them in an internal FIFO. It issues single-word writes to consecutive word addresses starting at a programmed base, honouring `waitrequest`. It is the write-side counterpart of the filter's flash read pipeline, and signals completion to the custom-instruction control logic by pulse and optional interrupt.

## Interface

Parameters:
- `ADDR_W`, 24: SDRAM byte-address width.
- `COUNT_W`, 20: width of the word-count register.
- `FIFO_DEPTH`, 16: internal FIFO depth in words; must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `cfg_start`, in, 1: one-cycle request to begin a transfer.
- `cfg_base`, in, ADDR_W: byte base address; bits [1:0] are ignored and treated as 0.
- `cfg_count`, in, COUNT_W: number of words to write.
- `busy`, out, 1: transfer in progress.
- `done_pulse`, out, 1: one-cycle pulse when the final word has been accepted by the slave.
- `written_count`, out, COUNT_W: words accepted by the slave in the current or most recent transfer.
- `in_valid`, in, 1: input sample valid.
- `in_data`, in, 32: input sample.
- `in_ready`, out, 1: block accepts `in_data` this cycle.
- `avm_address`, out, ADDR_W: write byte address.
- `avm_write`, out, 1: write request.
- `avm_writedata`, out, 32: write data.
- `avm_waitrequest`, in, 1: slave stall.
- `irq`, out, 1: completion interrupt (see Configuration).
- `irq_ack`, in, 1: clears `irq`.

## Operation

- States: IDLE, RUN.
- IDLE → RUN on `cfg_start` with `cfg_count != 0`. On entry:
  - latch base with bits [1:0] forced to 0;
  - latch count into `remaining`;
  - clear `written_count` and the input counter;
  - empty the FIFO.
- `cfg_start` with `cfg_count == 0` is ignored. `cfg_start` in RUN is ignored.
- `in_ready` = RUN && FIFO not full && input counter < latched count. Words beyond the count are never accepted.
- A handshake (`in_valid && in_ready`) pushes `in_data` into the FIFO and increments the input counter.
- When the FIFO is non-empty in RUN, present the head word: `avm_write`=1, `avm_writedata`=head, `avm_address`=current address.
- A write is accepted in any cycle with `avm_write && !avm_waitrequest`. On acceptance:
  - pop the FIFO;
  - address += 4, wrapping modulo 2^ADDR_W;
  - `written_count` += 1;
  - `remaining` −= 1.
- Acceptance with `remaining == 1` → IDLE. In the next cycle: `done_pulse`=1, `busy`=0, `irq` set.
- FIFO push and pop may occur in the same cycle; occupancy is unchanged and ordering is strictly FIFO.
- `written_count` holds its final value in IDLE until the next accepted start.

## Timing

- Reset values: `busy`=0, `done_pulse`=0, `written_count`=0, `in_ready`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `irq`=0. FIFO is emptied and state is IDLE.
- Reset mid-transfer aborts immediately. Any pending write is dropped and no `done_pulse` is generated.
- Start latency: `cfg_start` at cycle t → `busy`=1 and `in_ready` may be 1 at t+1.
- Input-to-bus latency: a handshake at cycle t with an empty FIFO → `avm_write`=1 with that data at t+1.
- Throughput: one word per cycle when `in_valid`=1 and `avm_waitrequest`=0.
- While `avm_write && avm_waitrequest`, `avm_address`, `avm_writedata` and `avm_write` are held stable. `avm_write` never deasserts before acceptance.
- `avm_write` is registered. It deasserts in the cycle after acceptance if the FIFO becomes empty.
- Completion: final acceptance at cycle t → `done_pulse`=1, `busy`=0, `irq`=1 at t+1.
- `irq_ack` at cycle t clears `irq` at t+1. If completion sets `irq` in the same cycle as `irq_ack`, set wins.

## Configuration

- Macro: `SD_RESULT_WRITER_IRQ_EN`.
- Defined: `irq` is a sticky register, set on completion and cleared by `irq_ack` or reset.
- Undefined: `irq` is tied to 0, `irq_ack` is ignored, and no interrupt logic is synthesised. `done_pulse` behaviour is unchanged.

## Test plan

- Basic transfer: `cfg_base`=0x000100, `cfg_count`=4, inputs 0xA0000001..0xA0000004 back-to-back, `waitrequest`=0.
  - Required: writes at 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Required: `done_pulse` one cycle after the 4th write, `written_count`=4, `irq`=1.
- Stall: same setup, `waitrequest` held high for 3 cycles on the 2nd write.
  - Required: address 0x104 and data 0xA0000002 stable for all 4 cycles, no duplicate write, order preserved.
- Backpressure: `cfg_count`=20, `waitrequest` held high, `in_valid` held high.
  - Required: `in_ready` drops after 16 accepts.
  - Required: after `waitrequest` is released, all 20 words are written in order and the 21st offered word is never accepted.
- Ignored starts:
  - `cfg_start` with `cfg_count`=0 → `busy` stays 0.
  - `cfg_start` during RUN with a new base → current transfer unaffected.
- Alignment and wrap: `cfg_base`=0xFFFFFE, `cfg_count`=2.
  - Required: writes at 0xFFFFFC, then 0x000000.
- Reset mid-run: assert `reset` after 2 of 8 words.
  - Required: all outputs at reset values next cycle and no `done_pulse`.
  - Required: a subsequent start with `cfg_count`=1 completes normally.
- `SD_RESULT_WRITER_IRQ_EN` undefined: repeat the basic transfer. Required: `irq` stays 0 and `done_pulse` is still asserted.

Source files
------------

// File: rtl/sd_result_writer.sv
// sd_result_writer: Avalon-MM write master that drains 32-bit filtered samples
// from a valid/ready stream through an internal FIFO into SDRAM, one word per
// write, at consecutive word addresses from a programmed base.
// Optional feature macro: SD_RESULT_WRITER_IRQ_EN (sticky completion interrupt).
module sd_result_writer #(
    parameter int ADDR_W     = 24,
    parameter int COUNT_W    = 20,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [COUNT_W-1:0] cfg_count,
    output logic               busy,
    output logic               done_pulse,
    output logic [COUNT_W-1:0] written_count,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic               avm_waitrequest,
    output logic               irq,
    input  logic               irq_ack
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  addr;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] total_count;
    logic [COUNT_W-1:0] in_cnt;
    logic [COUNT_W-1:0] written_cnt;
    logic               done_r;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic               push, pop, start_ok, last_accept;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign busy          = (state == RUN);
    assign done_pulse    = done_r;
    assign written_count = written_cnt;
    assign avm_address   = addr;
    assign avm_writedata = avm_write ? mem[rd_ptr[PTR_W-1:0]] : 32'h0;

    assign push        = in_valid && in_ready;
    assign pop         = avm_write && !avm_waitrequest;
    assign last_accept = pop && (remaining == COUNT_W'(1));

    // Next-state and handshake decode; all outputs derive from registered state.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        in_ready   = 1'b0;
        avm_write  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start && (cfg_count != '0)) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready  = !fifo_full && (in_cnt < total_count);
                avm_write = !fifo_empty;
                if (last_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: state, pointers, counters, address and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_cnt      <= '0;
            written_cnt <= '0;
            remaining   <= '0;
            total_count <= '0;
            addr        <= '0;
            done_r      <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= last_accept;
            if (start_ok) begin
                addr        <= cfg_base & ~ADDR_W'(3);
                remaining   <= cfg_count;
                total_count <= cfg_count;
                written_cnt <= '0;
                in_cnt      <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                    in_cnt <= in_cnt + COUNT_W'(1);
                end
                if (pop) begin
                    rd_ptr      <= rd_ptr + (PTR_W+1)'(1);
                    addr        <= addr + ADDR_W'(4);
                    written_cnt <= written_cnt + COUNT_W'(1);
                    remaining   <= remaining - COUNT_W'(1);
                end
            end
        end
    end

    // FIFO storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= in_data;
        end
    end

`ifdef SD_RESULT_WRITER_IRQ_EN
    logic irq_r;

    // Sticky interrupt: completion sets it and wins over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else if (last_accept) begin
            irq_r <= 1'b1;
        end else if (irq_ack) begin
            irq_r <= 1'b0;
        end
    end

    assign irq = irq_r;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_sd_result_writer.sv
// Testbench for sd_result_writer: table-driven cycle vectors for the basic and
// stalled transfers, then directed sequences for backpressure, ignored starts,
// alignment/wrap, reset mid-run and interrupt acknowledge priority.
module tb_sd_result_writer;

    localparam int ADDR_W     = 24;
    localparam int COUNT_W    = 20;
    localparam int FIFO_DEPTH = 16;
`ifdef SD_RESULT_WRITER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_start = 1'b0;
    logic [ADDR_W-1:0]  cfg_base = '0;
    logic [COUNT_W-1:0] cfg_count = '0;
    logic               busy, done_pulse, in_ready, avm_write, irq;
    logic [COUNT_W-1:0] written_count;
    logic               in_valid = 1'b0;
    logic [31:0]        in_data = '0;
    logic [ADDR_W-1:0]  avm_address;
    logic [31:0]        avm_writedata;
    logic               avm_waitrequest = 1'b0;
    logic               irq_ack = 1'b0;

    sd_result_writer #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base(cfg_base),
        .cfg_count(cfg_count), .busy(busy), .done_pulse(done_pulse),
        .written_count(written_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus / stream monitor: records accepted writes and input handshakes.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          in_acc = 0;
    int          done_cnt = 0;
    logic        irq_at_done = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_write && !avm_waitrequest) begin
                wr_addr_q.push_back(32'(avm_address));
                wr_data_q.push_back(avm_writedata);
            end
            if (in_valid && in_ready) in_acc++;
            if (done_pulse) done_cnt++;
        end
    end

    typedef struct {
        logic               st;
        logic [ADDR_W-1:0]  b;
        logic [COUNT_W-1:0] c;
        logic               vl;
        logic [31:0]        d;
        logic               stl;
        logic               ak;
        logic               eb, er, ew;
        logic [ADDR_W-1:0]  ea;
        logic [31:0]        ed;
        logic               edn, eirq;
        logic [COUNT_W-1:0] ewc;
    } vec_t;

    function automatic vec_t v(input logic st, input logic [ADDR_W-1:0] b,
                               input logic [COUNT_W-1:0] c, input logic vl,
                               input logic [31:0] d, input logic stl, input logic ak,
                               input logic eb, input logic er, input logic ew,
                               input logic [ADDR_W-1:0] ea, input logic [31:0] ed,
                               input logic edn, input logic eirq,
                               input logic [COUNT_W-1:0] ewc);
        vec_t r;
        r.st = st; r.b = b; r.c = c; r.vl = vl; r.d = d; r.stl = stl; r.ak = ak;
        r.eb = eb; r.er = er; r.ew = ew; r.ea = ea; r.ed = ed;
        r.edn = edn; r.eirq = eirq; r.ewc = ewc;
        return r;
    endfunction

    // Start a transfer and stream d0, d0+1, ... until done_pulse or a bound.
    task automatic xfer(input logic [ADDR_W-1:0] b, input logic [COUNT_W-1:0] c,
                        input logic [31:0] d0, input string name);
        bit seen = 0;
        int n = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
        in_acc = 0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_base = b; cfg_count = c;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        while (!seen && n < 200) begin
            in_valid = 1'b1;
            in_data  = d0 + 32'(in_acc);
            @(negedge clk);
            if (done_pulse) begin
                seen = 1;
                irq_at_done = irq;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({name, " done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vecs[$];

    initial begin
        int n;
        int base_done;
        // Basic transfer, then irq acknowledge.
        vecs.push_back(v(1,'h100,4, 0,0,0,0, 0,0,0,0,0, 0,0,0));
        vecs.push_back(v(0,0,0, 1,'hA0000001,0,0, 1,1,0,0,0, 0,0,0));
        vecs.push_back(v(0,0,0, 1,'hA0000002,0,0, 1,1,1,'h100,'hA0000001, 0,0,0));
        vecs.push_back(v(0,0,0, 1,'hA0000003,0,0, 1,1,1,'h104,'hA0000002, 0,0,1));
        vecs.push_back(v(0,0,0, 1,'hA0000004,0,0, 1,1,1,'h108,'hA0000003, 0,0,2));
        vecs.push_back(v(0,0,0, 0,0,0,0, 1,0,1,'h10C,'hA0000004, 0,0,3));
        vecs.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0,0, 1,IRQ_ON,4));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,0,0,0,0, 0,IRQ_ON,4));
        // Same transfer with the second write stalled for three cycles.
        vecs.push_back(v(1,'h100,4, 0,0,0,0, 0,0,0,0,0, 0,0,4));
        vecs.push_back(v(0,0,0, 1,'hA0000001,0,0, 1,1,0,0,0, 0,0,0));
        vecs.push_back(v(0,0,0, 1,'hA0000002,0,0, 1,1,1,'h100,'hA0000001, 0,0,0));
        vecs.push_back(v(0,0,0, 1,'hA0000003,1,0, 1,1,1,'h104,'hA0000002, 0,0,1));
        vecs.push_back(v(0,0,0, 1,'hA0000004,1,0, 1,1,1,'h104,'hA0000002, 0,0,1));
        vecs.push_back(v(0,0,0, 0,0,1,0, 1,0,1,'h104,'hA0000002, 0,0,1));
        vecs.push_back(v(0,0,0, 0,0,0,0, 1,0,1,'h104,'hA0000002, 0,0,1));
        vecs.push_back(v(0,0,0, 0,0,0,0, 1,0,1,'h108,'hA0000003, 0,0,2));
        vecs.push_back(v(0,0,0, 0,0,0,0, 1,0,1,'h10C,'hA0000004, 0,0,3));
        vecs.push_back(v(0,0,0, 0,0,0,0, 0,0,0,0,0, 1,IRQ_ON,4));
        vecs.push_back(v(0,0,0, 0,0,0,1, 0,0,0,0,0, 0,IRQ_ON,4));

        // Reset state.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done_pulse), 0);
        check("rst wcount", 32'(written_count), 0);
        check("rst in_ready", 32'(in_ready), 0);
        check("rst avm_write", 32'(avm_write), 0);
        check("rst avm_address", 32'(avm_address), 0);
        check("rst avm_writedata", avm_writedata, 0);
        check("rst irq", 32'(irq), 0);

        // Table-driven cycle vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            cfg_start = vecs[i].st; cfg_base = vecs[i].b; cfg_count = vecs[i].c;
            in_valid = vecs[i].vl; in_data = vecs[i].d;
            avm_waitrequest = vecs[i].stl; irq_ack = vecs[i].ak;
            @(negedge clk);
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].eb));
            check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vecs[i].er));
            check($sformatf("row%0d avm_write", i), 32'(avm_write), 32'(vecs[i].ew));
            if (vecs[i].ew) begin
                check($sformatf("row%0d avm_address", i), 32'(avm_address), 32'(vecs[i].ea));
                check($sformatf("row%0d avm_writedata", i), avm_writedata, vecs[i].ed);
            end
            check($sformatf("row%0d done_pulse", i), 32'(done_pulse), 32'(vecs[i].edn));
            check($sformatf("row%0d irq", i), 32'(irq), 32'(vecs[i].eirq));
            check($sformatf("row%0d written_count", i), 32'(written_count), 32'(vecs[i].ewc));
        end
        @(posedge clk); #1;
        cfg_start = 0; in_valid = 0; avm_waitrequest = 0; irq_ack = 0;
        @(negedge clk);
        check("post_ack irq", 32'(irq), 0);

        // Start with zero count is ignored.
        @(posedge clk); #1;
        cfg_start = 1; cfg_base = 'h300; cfg_count = 0;
        @(posedge clk); #1;
        cfg_start = 0;
        @(negedge clk);
        check("zero_count busy", 32'(busy), 0);
        check("zero_count in_ready", 32'(in_ready), 0);

        // Start during RUN is ignored.
        wr_addr_q.delete(); wr_data_q.delete(); in_acc = 0;
        base_done = done_cnt;
        @(posedge clk); #1;
        cfg_start = 1; cfg_base = 'h200; cfg_count = 3;
        @(posedge clk); #1;
        cfg_start = 0; in_valid = 1; in_data = 'hC0000000;
        @(posedge clk); #1;
        in_data = 'hC0000001; cfg_start = 1; cfg_base = 'h800; cfg_count = 5;
        @(posedge clk); #1;
        cfg_start = 0; in_data = 'hC0000002;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (done_cnt == base_done && n < 20) begin @(posedge clk); #1; n++; end
        check("run_start done_count", 32'(done_cnt - base_done), 1);
        check("run_start nwrites", 32'(wr_addr_q.size()), 3);
        for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
            check($sformatf("run_start addr%0d", k), wr_addr_q[k], 32'h200 + 32'(4*k));
            check($sformatf("run_start data%0d", k), wr_data_q[k], 32'hC0000000 + 32'(k));
        end
        check("run_start wcount", 32'(written_count), 3);

        // Alignment and wrap, with irq_ack held: completion set wins.
        irq_ack = 1;
        xfer('hFFFFFE, 2, 'hD0000000, "wrap");
        check("wrap irq_set_wins", 32'(irq_at_done), 32'(IRQ_ON));
        @(negedge clk);
        check("wrap irq_cleared", 32'(irq), 0);
        irq_ack = 0;
        check("wrap nwrites", 32'(wr_addr_q.size()), 2);
        if (wr_addr_q.size() == 2) begin
            check("wrap addr0", wr_addr_q[0], 32'hFFFFFC);
            check("wrap addr1", wr_addr_q[1], 32'h000000);
            check("wrap data1", wr_data_q[1], 32'hD0000001);
        end
        check("wrap accepted", 32'(in_acc), 2);
        check("wrap wcount", 32'(written_count), 2);

        // Backpressure: slave stalled, source always valid.
        wr_addr_q.delete(); wr_data_q.delete(); in_acc = 0;
        base_done = done_cnt;
        @(posedge clk); #1;
        avm_waitrequest = 1; cfg_start = 1; cfg_base = 'h400; cfg_count = 20;
        @(posedge clk); #1;
        cfg_start = 0;
        for (int k = 0; k < 30; k++) begin
            in_valid = 1; in_data = 32'hE0000000 + 32'(in_acc);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp accepted_full", 32'(in_acc), 16);
        check("bp in_ready_low", 32'(in_ready), 0);
        check("bp no_writes", 32'(wr_addr_q.size()), 0);
        check("bp held_addr", 32'(avm_address), 32'h400);
        check("bp held_data", avm_writedata, 32'hE0000000);
        @(posedge clk); #1;
        avm_waitrequest = 0;
        n = 0;
        while (done_cnt == base_done && n < 100) begin
            in_valid = 1; in_data = 32'hE0000000 + 32'(in_acc);
            @(posedge clk); #1; n++;
        end
        repeat (5) begin
            in_data = 32'hE0000000 + 32'(in_acc);
            @(posedge clk); #1;
        end
        in_valid = 0;
        check("bp done_count", 32'(done_cnt - base_done), 1);
        check("bp accepted_total", 32'(in_acc), 20);
        check("bp nwrites", 32'(wr_addr_q.size()), 20);
        for (int k = 0; k < 20 && k < wr_addr_q.size(); k++) begin
            check($sformatf("bp addr%0d", k), wr_addr_q[k], 32'h400 + 32'(4*k));
            check($sformatf("bp data%0d", k), wr_data_q[k], 32'hE0000000 + 32'(k));
        end
        check("bp wcount", 32'(written_count), 20);

        // Reset mid-run after two writes.
        wr_addr_q.delete(); wr_data_q.delete(); in_acc = 0;
        @(posedge clk); #1;
        cfg_start = 1; cfg_base = 'h600; cfg_count = 8;
        @(posedge clk); #1;
        cfg_start = 0;
        n = 0;
        while (wr_addr_q.size() < 2 && n < 30) begin
            in_valid = 1; in_data = 32'hF1000000 + 32'(in_acc);
            @(posedge clk); #1; n++;
        end
        check("mid_reset two_writes", 32'(wr_addr_q.size()), 2);
        reset = 1; avm_waitrequest = 1; in_valid = 0;
        base_done = done_cnt;
        @(posedge clk); #1;
        reset = 0; avm_waitrequest = 0;
        @(negedge clk);
        check("mid_reset busy", 32'(busy), 0);
        check("mid_reset done", 32'(done_pulse), 0);
        check("mid_reset wcount", 32'(written_count), 0);
        check("mid_reset in_ready", 32'(in_ready), 0);
        check("mid_reset avm_write", 32'(avm_write), 0);
        check("mid_reset avm_address", 32'(avm_address), 0);
        check("mid_reset avm_writedata", avm_writedata, 0);
        check("mid_reset irq", 32'(irq), 0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_reset no_done", 32'(done_cnt - base_done), 0);
        check("mid_reset no_more_writes", 32'(wr_addr_q.size()), 2);

        xfer('h700, 1, 'hF0000000, "post_reset");
        check("post_reset nwrites", 32'(wr_addr_q.size()), 1);
        if (wr_addr_q.size() == 1) begin
            check("post_reset addr", wr_addr_q[0], 32'h700);
            check("post_reset data", wr_data_q[0], 32'hF0000000);
        end
        check("post_reset wcount", 32'(written_count), 1);
        check("post_reset irq", 32'(irq_at_done), 32'(IRQ_ON));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
